// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder (state encoding, word geometry).
// Optional feature macro used by mem_responder: MEM_RESP_ALIGN_CHECK_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int WORD_BYTES       = 8;
    localparam int WORD_OFFSET_BITS = 3;
    localparam int WAIT_CNT_W       = 4;

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port synchronous 64-bit SRAM with registered read data; kept separate so a
// vendor macro can replace it. Read data only changes on an enabled read.
module mem_resp_sram #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [63:0]           wdata,
    output logic [63:0]           rdata
);

    logic [63:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES wait cycles, then one SRAM
// access and a one-cycle DONE. Define MEM_RESP_ALIGN_CHECK_EN to error misaligned requests.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] PADDR,
    input  logic        HWRITE,
    input  logic [63:0] PDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    we_q;
    logic [63:0]             wdata_q;
    logic                    rd_vld_q;
    logic                    misalign;
    logic                    accept;
    logic                    sram_en;
    logic [63:0]             sram_rdata;

    assign accept = req_valid && HREADY;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic [WORD_OFFSET_BITS-1:0] off_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q <= '0;
        end else if (accept) begin
            off_q <= PADDR[WORD_OFFSET_BITS-1:0];
        end
    end
    assign misalign = (off_q != '0);
`else
    assign misalign = 1'b0;
`endif

    // Upper address bits wrap away; the byte offset only matters with the align check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PADDR[63:DEPTH_LOG2+WORD_OFFSET_BITS], PADDR[WORD_OFFSET_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req_valid) begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A reset coinciding with the ACCESS edge suppresses the SRAM write.
    always_comb begin
        HREADY  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        HRESP   = (state_q == ST_DONE) && misalign;
        sram_en = (state_q == ST_ACCESS) && !misalign && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                idx_q   <= PADDR[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
                we_q    <= HWRITE;
                wdata_q <= PDATA;
            end
            if (sram_en && !we_q) begin
                rd_vld_q <= 1'b1;
            end
        end
    end

    mem_resp_sram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clk  (clk),
        .en   (sram_en),
        .we   (we_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(sram_rdata)
    );

    // The SRAM read register holds the last read; the valid flag gives HRDATA its reset-to-zero.
    assign HRDATA = rd_vld_q ? sram_rdata : 64'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a scoreboard queue checked at each DONE cycle.
module tb_mem_responder;

    localparam int WS  = 2;
    localparam int DL2 = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] PADDR;
    logic        HWRITE;
    logic [63:0] PDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .PADDR    (PADDR),
        .HWRITE   (HWRITE),
        .PDATA    (PDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    typedef struct {
        logic [63:0] data;
        logic        resp;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mdl [int];
    logic [63:0] last_rd = 64'd0;
    int          checks = 0;
    int          errors = 0;
    bit          b2b = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: DONE is the first HREADY-high cycle after a low stretch.
    int   cyc = 0, low_cnt = 0, last_done = 0, b2b_n = 0;
    logic prev_rdy = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_rdy = 1'b1;
            low_cnt  = 0;
        end else begin
            if (!HREADY) chk("hresp_low_when_busy", {63'd0, HRESP}, 64'd0);
            if (HREADY && !prev_rdy) begin
                chk("busy_cycles", 64'(low_cnt), 64'(WS + 1));
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_hrdata", HRDATA, e.data);
                    chk("done_hresp", {63'd0, HRESP}, {63'd0, e.resp});
                end
                if (b2b) begin
                    if (b2b_n > 0) chk("b2b_spacing", 64'(cyc - last_done), 64'(WS + 2));
                    b2b_n++;
                end
                last_done = cyc;
            end
            low_cnt  = HREADY ? 0 : low_cnt + 1;
            prev_rdy = HREADY;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic wr, input logic [63:0] d,
                         input bit keep, input bit track);
        int   n = 0;
        int   idx;
        bit   err = 0;
        exp_t e;
        while (HREADY !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("issue_timeout", {63'd0, HREADY}, 64'd1);
        req_valid = 1'b1;
        PADDR     = a;
        HWRITE    = wr;
        PDATA     = d;
        if (track) begin
            idx = int'((a >> 3) & ((64'd1 << DL2) - 1));
`ifdef MEM_RESP_ALIGN_CHECK_EN
            err = (a[2:0] != 3'd0);
`endif
            if (err) begin
                e.data = last_rd; e.resp = 1'b1;
            end else if (wr) begin
                mdl[idx] = d;
                e.data = last_rd; e.resp = 1'b0;
            end else begin
                last_rd = mdl[idx];
                e.data = last_rd; e.resp = 1'b0;
            end
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; PADDR = '0; HWRITE = 1'b0; PDATA = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hready", {63'd0, HREADY}, 64'd1);
            chk("idle_hrdata", HRDATA, 64'd0);
            chk("idle_hresp", {63'd0, HRESP}, 64'd0);
        end
        @(posedge clk); #1;

        issue(64'h40, 1'b1, 64'hDEADBEEF_CAFEF00D, 0, 1);
        issue(64'h40, 1'b0, 64'd0, 0, 1);
        drain();

        issue(64'h0,  1'b1, 64'd1, 0, 1);
        issue(64'h8,  1'b1, 64'd2, 0, 1);
        issue(64'h10, 1'b1, 64'd3, 0, 1);
        drain();
        b2b = 1;
        issue(64'h0,  1'b0, 64'd0, 1, 1);
        issue(64'h8,  1'b0, 64'd0, 1, 1);
        issue(64'h10, 1'b0, 64'd0, 0, 1);
        drain();
        b2b = 0;
        chk("b2b_done_count", 64'(b2b_n), 64'd3);

        issue(64'h8000, 1'b1, 64'h55, 0, 1);
        issue(64'h0,    1'b0, 64'd0,  0, 1);
        drain();

        issue(64'h80, 1'b1, 64'h1111_2222_3333_4444, 0, 1);
        drain();
        issue(64'h80, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = 64'd0;
        @(negedge clk);
        chk("rst_mid_hready", {63'd0, HREADY}, 64'd1);
        chk("rst_mid_hrdata", HRDATA, 64'd0);
        @(posedge clk); #1;
        issue(64'h80, 1'b0, 64'd0, 0, 1);
        drain();

        issue(64'h44, 1'b0, 64'd0, 0, 1);
        drain();
        @(negedge clk);
        chk("hresp_after_done", {63'd0, HRESP}, 64'd0);
        chk("hrdata_after_0x44", HRDATA, last_rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
